// File: rtl/pe_v_boundary_pkg.sv
// rtl/pe_v_boundary_pkg.sv - shared constants, types and CORDIC step for the vectoring boundary cell
// Purpose: widths, scale constant K, pipeline stage boundaries and the direction
//          encoding shared with the rotation PE; one vectoring micro-rotation helper.
// Ports:   none (package).
package pe_v_boundary_pkg;

   localparam int BITWIDTH   = 18;
   localparam int CORDIC_NUM = 14;
   localparam int PIPE_NUM   = 4;

   // Two guard bits absorb the CORDIC gain (~1.65 * sqrt(2)) without overflow.
   localparam int DW = BITWIDTH + 2;

   // K ~= 0.60725 in Q1.14, undoes the accumulated CORDIC gain.
   localparam logic [14:0] K_SCALE = 15'b010011011011101;
   localparam int          K_FRAC  = 14;

   localparam int R_MAX = (1 << (BITWIDTH - 1)) - 1;

   // Iteration ranges per pipeline stage.
   localparam int S0_FIRST = 0;
   localparam int S0_LAST  = 3;
   localparam int S1_FIRST = 4;
   localparam int S1_LAST  = 8;
   localparam int S2_FIRST = 9;
   localparam int S2_LAST  = 13;

   // Direction encoding, identical in the rotation PE.
   localparam logic DIR_CCW = 1'b1;
   localparam logic DIR_CW  = 1'b0;

   typedef logic signed [DW-1:0] cdata_t;

   function automatic logic cordic_dir(input cdata_t y);
      return (y < 0) ? DIR_CCW : DIR_CW;
   endfunction

   // One vectoring micro-rotation with shift sh; drives Y toward zero.
   function automatic void cordic_iter(input cdata_t x, input cdata_t y, input int sh,
                                       output cdata_t x_n, output cdata_t y_n);
      if (cordic_dir(y) == DIR_CCW) begin
         x_n = x - (y >>> sh);
         y_n = y + (x >>> sh);
      end else begin
         x_n = x + (y >>> sh);
         y_n = y - (x >>> sh);
      end
   endfunction

endpackage

// File: rtl/pe_v_boundary_if.sv
// rtl/pe_v_boundary_if.sv - sample/result bus of the vectoring boundary cell
// Purpose: bundles the input sample handshake and the skewed direction / magnitude outputs.
// Signals: valid_i, clear_i, x_i (sample in); start_o, angle_d_o (to rotation PE);
//          valid_o, r_o, slot_o (updated magnitude out).
// Modports: master = producer of samples / consumer of results, slave = the cell.
interface pe_v_boundary_if;
   import pe_v_boundary_pkg::*;

   logic                         valid_i;
   logic                         clear_i;
   logic signed [BITWIDTH-1:0]   x_i;
   logic                         start_o;
   logic        [CORDIC_NUM-1:0] angle_d_o;
   logic                         valid_o;
   logic        [BITWIDTH-1:0]   r_o;
   logic        [1:0]            slot_o;

   modport master (
      output valid_i, clear_i, x_i,
      input  start_o, angle_d_o, valid_o, r_o, slot_o
   );

   modport slave (
      input  valid_i, clear_i, x_i,
      output start_o, angle_d_o, valid_o, r_o, slot_o
   );

endinterface

// File: rtl/cordic_v_core.sv
// rtl/cordic_v_core.sv - 4-stage vectoring CORDIC pipeline with gain scaling
// Purpose: iterations 0-3 / 4-8 / 9-13 in stages 0-2, K scaling and saturation in stage 3.
// Ports:   clk, rst_n      clock, async active-low reset
//          en[3:0]         load enable per stage (valid entering that stage)
//          x_in, y_in      stage-0 operands
//          angle_d         skewed direction bits {stage2, stage1, stage0}
//          r_next          saturated magnitude about to be loaded (for write-back)
//          r_q             registered saturated magnitude
module cordic_v_core
   import pe_v_boundary_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [PIPE_NUM-1:0]   en,
   input  cdata_t                x_in,
   input  cdata_t                y_in,
   output logic [CORDIC_NUM-1:0] angle_d,
   output logic [BITWIDTH-1:0]   r_next,
   output logic [BITWIDTH-1:0]   r_q
);

   localparam int PW = DW + 15;

   cdata_t x0_q, y0_q, x1_q, y1_q, x2_q;
   logic [S0_LAST-S0_FIRST:0] d0_q;
   logic [S1_LAST-S1_FIRST:0] d1_q;
   logic [S2_LAST-S2_FIRST:0] d2_q;

   cdata_t s0_x, s0_y, s1_x, s1_y, s2_x;
   logic [CORDIC_NUM-1:0] d_all;
   logic signed [PW-1:0]  prod, scaled;

   // One 14-step chain, restarted from the stage register at each stage boundary,
   // so every direction bit is produced exactly once.
   always_comb begin : chain
      cdata_t x, y, xn, yn;
      d_all = '0;
      s0_x  = '0;
      s0_y  = '0;
      s1_x  = '0;
      s1_y  = '0;
      s2_x  = '0;
      x     = x_in;
      y     = y_in;
      for (int i = 0; i < CORDIC_NUM; i++) begin
         if (i == S1_FIRST) begin
            x = x0_q;
            y = y0_q;
         end
         if (i == S2_FIRST) begin
            x = x1_q;
            y = y1_q;
         end
         d_all[i] = cordic_dir(y);
         cordic_iter(x, y, i, xn, yn);
         x = xn;
         y = yn;
         if (i == S0_LAST) begin
            s0_x = x;
            s0_y = y;
         end
         if (i == S1_LAST) begin
            s1_x = x;
            s1_y = y;
         end
         if (i == S2_LAST) s2_x = x;
      end
   end

   // X is non-negative after vectoring; the negative clamp only guards the range.
   always_comb begin
      prod   = PW'(x2_q) * $signed(PW'(K_SCALE));
      scaled = prod >>> K_FRAC;
      if (scaled[PW-1])
         r_next = '0;
      else if (scaled > PW'(R_MAX))
         r_next = BITWIDTH'(R_MAX);
      else
         r_next = scaled[BITWIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x0_q <= '0;
         y0_q <= '0;
         d0_q <= '0;
         x1_q <= '0;
         y1_q <= '0;
         d1_q <= '0;
         x2_q <= '0;
         d2_q <= '0;
         r_q  <= '0;
      end else begin
         if (en[0]) begin
            x0_q <= s0_x;
            y0_q <= s0_y;
            d0_q <= d_all[S0_LAST:S0_FIRST];
         end
         if (en[1]) begin
            x1_q <= s1_x;
            y1_q <= s1_y;
            d1_q <= d_all[S1_LAST:S1_FIRST];
         end
         if (en[2]) begin
            x2_q <= s2_x;
            d2_q <= d_all[S2_LAST:S2_FIRST];
         end
         if (en[3]) r_q <= r_next;
      end
   end

   assign angle_d = {d2_q, d1_q, d0_q};

endmodule

// File: rtl/pe_v_boundary.sv
// rtl/pe_v_boundary.sv - vectoring CORDIC boundary cell, 4 time-interleaved problems
// Purpose: vectors x_i against the stored diagonal r of the current slot, writes the
//          new magnitude back and emits skewed direction bits for the rotation PE.
// Ports:   clk    clock, rising edge
//          rst_n  async active-low reset
//          bus    pe_v_boundary_if.slave (valid_i, clear_i, x_i, start_o, angle_d_o,
//                 valid_o, r_o, slot_o)
module pe_v_boundary
   import pe_v_boundary_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   pe_v_boundary_if.slave       bus
);

   logic [1:0]          slot_cnt;
   logic [BITWIDTH-1:0] r_mem [PIPE_NUM];
   logic [1:0]          tag0, tag1, tag2, tag3;
   logic                v0, v1, v2, v3;

   cdata_t                x_op, y_op;
   logic [CORDIC_NUM-1:0] angle_d;
   logic [BITWIDTH-1:0]   r_next, r_q;

   // r_mem entries are non-negative, so zero-extension keeps them positive.
   assign x_op = bus.clear_i ? '0 : $signed({2'b00, r_mem[slot_cnt]});
   assign y_op = DW'(bus.x_i);

   cordic_v_core u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      ({v2, v1, v0, bus.valid_i}),
      .x_in    (x_op),
      .y_in    (y_op),
      .angle_d (angle_d),
      .r_next  (r_next),
      .r_q     (r_q)
   );

   // Write-back lands four cycles after issue, the same cycle the slot recurs,
   // so the feedback loop needs no bypass.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt <= '0;
         for (int i = 0; i < PIPE_NUM; i++) r_mem[i] <= '0;
         tag0 <= '0;
         tag1 <= '0;
         tag2 <= '0;
         tag3 <= '0;
         v0   <= 1'b0;
         v1   <= 1'b0;
         v2   <= 1'b0;
         v3   <= 1'b0;
      end else begin
         slot_cnt <= slot_cnt + 2'd1;
         v0 <= bus.valid_i;
         v1 <= v0;
         v2 <= v1;
         v3 <= v2;
         if (bus.valid_i) tag0 <= slot_cnt;
         if (v0) tag1 <= tag0;
         if (v1) tag2 <= tag1;
         if (v2) begin
            tag3         <= tag2;
            r_mem[tag2]  <= r_next;
         end
      end
   end

   assign bus.start_o   = v0;
   assign bus.angle_d_o = angle_d;
   assign bus.valid_o   = v3;
   assign bus.r_o       = r_q;
   assign bus.slot_o    = tag3;

endmodule

// File: tb/tb_pe_v_boundary.sv
// tb/tb_pe_v_boundary.sv - self-checking bench for pe_v_boundary
module tb_pe_v_boundary;
   import pe_v_boundary_pkg::*;

   localparam int HN = 2048;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   pe_v_boundary_if bus ();

   pe_v_boundary dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int t      = 0;
   int mem_m [4];

   // Per-cycle history: vld_h = sample accepted; d_h/r_h/s_h = latest accepted sample so far.
   logic        vld_h [HN];
   logic [13:0] d_h   [HN];
   int          r_h   [HN];
   int          s_h   [HN];

   typedef struct {
      int   x;
      int   lo;
      int   hi;
      logic d0;
   } vec_t;
   vec_t vecs [6];

   function automatic void cordic_ref(input longint xin, input longint yin,
                                      output logic [13:0] d, output int r);
      longint x, y, xn, p;
      x = xin;
      y = yin;
      for (int i = 0; i < 14; i++) begin
         d[i] = (y < 0);
         if (y < 0) begin
            xn = x - (y >>> i);
            y  = y + (x >>> i);
         end else begin
            xn = x + (y >>> i);
            y  = y - (x >>> i);
         end
         x = xn;
      end
      p = (x * 9949) >>> 14;
      if (p > 131071) r = 131071;
      else if (p < 0) r = 0;
      else r = int'(p);
   endfunction

   task automatic cmp(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, t, act, exp);
      end
   endtask

   task automatic cmp_range(input string name, input longint act, input longint lo, input longint hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d..%0d", name, t, act, lo, hi);
      end
   endtask

   task automatic model_accept(input logic v, input logic c, input int x);
      logic [13:0] d;
      int          r;
      longint      xo;
      if (v) begin
         xo = c ? 0 : longint'(mem_m[t % 4]);
         cordic_ref(xo, longint'(x), d, r);
         mem_m[t % 4] = r;
         vld_h[t] = 1'b1;
         d_h[t]   = d;
         r_h[t]   = r;
         s_h[t]   = t % 4;
      end else begin
         vld_h[t] = 1'b0;
         d_h[t]   = (t > 0) ? d_h[t-1] : '0;
         r_h[t]   = (t > 0) ? r_h[t-1] : 0;
         s_h[t]   = (t > 0) ? s_h[t-1] : 0;
      end
   endtask

   task automatic check_outputs();
      logic        e_start, e_v;
      logic [13:0] e_ang;
      int          e_r, e_s;
      e_start = 1'b0;
      e_v     = 1'b0;
      e_ang   = '0;
      e_r     = 0;
      e_s     = 0;
      if (t >= 1) begin
         e_start     = vld_h[t-1];
         e_ang[3:0]  = d_h[t-1][3:0];
      end
      if (t >= 2) e_ang[8:4]  = d_h[t-2][8:4];
      if (t >= 3) e_ang[13:9] = d_h[t-3][13:9];
      if (t >= 4) begin
         e_v = vld_h[t-4];
         e_r = r_h[t-4];
         e_s = s_h[t-4];
      end
      cmp("start_o",   bus.start_o,   e_start);
      cmp("angle_d_o", bus.angle_d_o, e_ang);
      cmp("valid_o",   bus.valid_o,   e_v);
      cmp("r_o",       bus.r_o,       e_r);
      cmp("slot_o",    bus.slot_o,    e_s);
   endtask

   task automatic tick(input logic v, input logic c, input int x);
      model_accept(v, c, x);
      bus.valid_i = v;
      bus.clear_i = c;
      bus.x_i     = x[BITWIDTH-1:0];
      @(posedge clk);
      #1;
      t++;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 0);
   endtask

   task automatic align0();
      while (t % 4 != 0) tick(1'b0, 1'b0, 0);
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      bus.valid_i = 1'b0;
      bus.clear_i = 1'b0;
      bus.x_i     = '0;
      #1;
      cmp("rst_valid_o", bus.valid_o,   0);
      cmp("rst_r_o",     bus.r_o,       0);
      cmp("rst_start_o", bus.start_o,   0);
      cmp("rst_angle",   bus.angle_d_o, 0);
      cmp("rst_slot_o",  bus.slot_o,    0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      t = 0;
      for (int i = 0; i < 4; i++) mem_m[i] = 0;
      check_outputs();
   endtask

   initial begin
      int n_valid;
      int exp_slot;

      vecs[0] = '{-1000,   998,    1002,   1'b1};
      vecs[1] = '{-131072, 131069, 131071, 1'b1};
      vecs[2] = '{131071,  131063, 131071, 1'b0};
      vecs[3] = '{0,       0,      0,      1'b0};
      vecs[4] = '{50000,   49992,  50008,  1'b0};
      vecs[5] = '{-77777,  77769,  77785,  1'b1};

      bus.valid_i = 1'b0;
      bus.clear_i = 1'b0;
      bus.x_i     = '0;
      #2;
      do_reset();

      // Idle after reset: outputs stay 0, slot counter free-runs and wraps.
      for (int i = 0; i < 8; i++) begin
         cmp("slot_cnt", dut.slot_cnt, t % 4);
         tick(1'b0, 1'b0, 0);
      end

      // Slot 0 clear with 1000.
      align0();
      tick(1'b1, 1'b1, 1000);
      cmp("d3_0_x1000", bus.angle_d_o[3:0], 0);
      tick(1'b0, 1'b0, 0);
      cmp("d4_x1000", bus.angle_d_o[4], 1);
      idle(2);
      cmp("valid_x1000", bus.valid_o, 1);
      cmp("slot_x1000", bus.slot_o, 0);
      cmp_range("r_x1000", bus.r_o, 998, 1002);

      // Slot 0 accumulate: 3000 then 4000 -> 5000.
      align0();
      tick(1'b1, 1'b1, 3000);
      idle(3);
      cmp_range("r_x3000", bus.r_o, 2998, 3002);
      tick(1'b1, 1'b0, 4000);
      idle(3);
      cmp_range("r_acc5000", bus.r_o, 4997, 5003);

      // All four slots interleaved, then a zero element in each.
      align0();
      n_valid  = 0;
      exp_slot = 0;
      for (int i = 0; i < 12; i++) begin
         if (i < 4)      tick(1'b1, 1'b1, 100 * (i + 1));
         else if (i < 8) tick(1'b1, 1'b0, 0);
         else            tick(1'b0, 1'b0, 0);
         if (bus.valid_o) begin
            n_valid++;
            cmp("slot_order", bus.slot_o, exp_slot);
            exp_slot = (exp_slot + 1) % 4;
         end
      end
      cmp("four_slot_count", n_valid, 8);

      // Single-shot clears from a table.
      for (int i = 0; i < 6; i++) begin
         tick(1'b1, 1'b1, vecs[i].x);
         cmp("tbl_d0", bus.angle_d_o[0], vecs[i].d0);
         idle(3);
         cmp("tbl_valid", bus.valid_o, 1);
         cmp_range("tbl_r", bus.r_o, vecs[i].lo, vecs[i].hi);
      end

      // Saturation: |(100000, 100000)| exceeds the range.
      tick(1'b1, 1'b1, 100000);
      idle(3);
      tick(1'b1, 1'b0, 100000);
      idle(3);
      cmp("r_saturated", bus.r_o, 131071);

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         int   xr;
         logic v, c;
         v = ($urandom_range(3, 0) != 0);
         c = ($urandom_range(4, 0) == 0);
         case ($urandom_range(7, 0))
            0:       xr = -131072;
            1:       xr = 131071;
            2:       xr = 0;
            default: xr = int'($urandom_range(262143, 0)) - 131072;
         endcase
         tick(v, c, xr);
      end

      // Reset two cycles after issue: nothing in flight may surface or write back.
      tick(1'b1, 1'b1, 5000);
      tick(1'b1, 1'b1, 6000);
      do_reset();
      for (int i = 0; i < 6; i++) begin
         tick(1'b0, 1'b0, 0);
         cmp("midrst_valid_o", bus.valid_o, 0);
      end
      for (int k = 0; k < 4; k++) cmp("midrst_r_mem", dut.r_mem[k], 0);
      tick(1'b1, 1'b0, -700);
      idle(3);
      cmp_range("midrst_r_fresh", bus.r_o, 697, 705);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
